// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter multiplexing NREQ byte requesters onto one uart_transmitter.
// Optional req_ack timeout is enabled with the UART_ARB_TIMEOUT_EN macro.
module uart_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int TMO_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tr_en,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*8-1:0]       data_i,
  output logic [NREQ-1:0]         ack_o,
  output logic [NREQ-1:0]         err_o,
  output logic [7:0]              tx_data,
  output logic                    req,
  input  logic                    req_ack,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int OW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TMO_W < 1) begin : g_cfg_check
    $error("uart_tx_arbiter: NREQ must be 2..8 and TMO_W at least 1");
  end

  typedef enum logic [1:0] {ARB_s, SEND_s, DONE_s} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [OW-1:0] winner;
  logic          any_req;
  logic          grant;
  logic          ack_hit;
  logic          tmo_hit;
  logic          tmo_full;

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Walk from the farthest candidate to the nearest so the requester right
  // after the last owner overwrites everyone else and wins.
  always_comb begin
    int cand;
    cand    = 0;
    winner  = owner;
    any_req = 1'b0;
    for (int d = NREQ; d >= 1; d--) begin
      cand = (int'(owner) + d) % NREQ;
      if (req_i[cand]) begin
        winner  = cand[OW-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    if (!tr_en) begin
      state_nxt = ARB_s;
    end else begin
      case (state)
        ARB_s: begin
          if (!req_ack && any_req) begin
            state_nxt = SEND_s;
            grant     = 1'b1;
          end
        end
        SEND_s: begin
          if (req_ack) begin
            state_nxt = DONE_s;
            ack_hit   = 1'b1;
          end else if (tmo_full) begin
            state_nxt = DONE_s;
            tmo_hit   = 1'b1;
          end
        end
        DONE_s: begin
          if (!req_ack) state_nxt = ARB_s;
        end
        default: state_nxt = ARB_s;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARB_s;
      req     <= 1'b0;
      busy    <= 1'b0;
      ack_o   <= '0;
      tx_data <= 8'hFF;
      owner   <= OW'(NREQ - 1);
    end else begin
      state <= state_nxt;
      req   <= (state_nxt == SEND_s);
      busy  <= (state_nxt != ARB_s);
      ack_o <= ack_hit ? onehot(owner) : '0;
      if (grant) begin
        tx_data <= data_i[8*int'(winner) +: 8];
        owner   <= winner;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_o   <= '0;
    end else begin
      if (grant) tmo_cnt <= '0;
      else if (state == SEND_s) tmo_cnt <= tmo_cnt + TMO_W'(1);
      err_o <= tmo_hit ? onehot(owner) : '0;
    end
  end

  assign tmo_full = (state == SEND_s) && (tmo_cnt == '1);
`else
  assign tmo_full = 1'b0;
  assign err_o    = '0;
`endif

endmodule
